// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and small helpers for the ALU-side shifters.
// The multicycle right shifter resolves one shift-amount bit per stage.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int NSTAGE  = 5;
    localparam int STAGE_W = 3;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NSTAGE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // SRA keeps replicating the current sign bit; SRL always fills with zero.
    function automatic logic fill_bit(input logic arith, input logic msb);
        return arith & msb;
    endfunction

endpackage

// File: rtl/sr_stage_mux.sv
// One stage of the multicycle right shifter: shift by 2^k when enabled.
// Built as a select among five fixed shifts so no variable barrel is needed.
module sr_stage_mux
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  work,
    input  logic [STAGE_W-1:0] k,
    input  logic               en,
    input  logic               fill,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = work;
        case (k)
            3'd0:    shifted = {fill, work[DATA_W-1:1]};
            3'd1:    shifted = {{2{fill}}, work[DATA_W-1:2]};
            3'd2:    shifted = {{4{fill}}, work[DATA_W-1:4]};
            3'd3:    shifted = {{8{fill}}, work[DATA_W-1:8]};
            3'd4:    shifted = {{16{fill}}, work[DATA_W-1:16]};
            default: shifted = work;
        endcase
        result = en ? shifted : work;
    end

endmodule

// File: rtl/sr_multicycle_shifter.sv
// Five-cycle SRL/SRA right shifter with a start/ready handshake.
// state | meaning
// IDLE  | waiting for ctrl_start
// SHIFT | applying stage k (0..4), one shift-amount bit per edge
// DONE  | result just written; data_resultRDY high; may accept a new start
module sr_multicycle_shifter
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic               ctrl_arith,
    input  logic               ctrl_start,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_resultRDY,
    output logic               busy
);

    shift_state_t       state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               arith_q, arith_d;
    logic [STAGE_W-1:0] k_q, k_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  stage_out;
    logic               stage_en;
    logic               stage_fill;

    assign stage_en   = amt_q[k_q];
    assign stage_fill = fill_bit(arith_q, work_q[DATA_W-1]);

    sr_stage_mux u_stage (
        .work   (work_q),
        .k      (k_q),
        .en     (stage_en),
        .fill   (stage_fill),
        .result (stage_out)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        amt_d      = amt_q;
        arith_d    = arith_q;
        k_d        = k_q;
        data_out_d = data_out_q;
        rdy_d      = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts exactly like IDLE so back-to-back requests lose no cycle.
                if (ctrl_start) begin
                    work_d  = data_in;
                    amt_d   = ctrl_shiftamt;
                    arith_d = ctrl_arith;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + 3'd1;
                if (k_q == LAST_STAGE) begin
                    data_out_d = stage_out;
                    rdy_d      = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            amt_q      <= '0;
            arith_q    <= 1'b0;
            k_q        <= '0;
            data_out_q <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            amt_q      <= amt_d;
            arith_q    <= arith_d;
            k_q        <= k_d;
            data_out_q <= data_out_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sr_multicycle_shifter.sv
// Directed-vector bench for the multicycle right shifter.
module tb_sr_multicycle_shifter;

    logic        clock;
    logic        reset;
    logic [31:0] data_in;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_arith;
    logic        ctrl_start;
    logic [31:0] data_out;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sr_multicycle_shifter dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .ctrl_arith     (ctrl_arith),
        .ctrl_start     (ctrl_start),
        .data_out       (data_out),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Issue one request and wait (bounded) for its completion pulse.
    // lat = edges from the accepting edge to the result; -1 on timeout.
    task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic ar,
                          output logic [31:0] res, output int lat, output int busy_bad);
        data_in       = d;
        ctrl_shiftamt = a;
        ctrl_arith    = ar;
        ctrl_start    = 1'b1;
        @(posedge clock); #1;
        ctrl_start    = 1'b0;
        data_in       = $urandom;
        ctrl_shiftamt = 5'($urandom);
        ctrl_arith    = 1'($urandom);
        lat      = 0;
        busy_bad = 0;
        while (data_resultRDY !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clock); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_bad++;
        res = data_out;
        if (lat >= 20) lat = -1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        data_in       = '0;
        ctrl_shiftamt = '0;
        ctrl_arith    = 1'b0;
        ctrl_start    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (data_out !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: data_out=%h rdy=%b busy=%b, required 0/0/0",
                     data_out, data_resultRDY, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat, bb;

        run_op(32'h8000_0000, 5'd31, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sra_80000000_31: got %h, required ffffffff", res);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL sra_latency: got %0d edges, required 5", lat);
        end
        n_checks++;
        if (bb !== 0) begin
            n_fail++;
            $display("FAIL sra_busy: %0d bad busy samples, required 0", bb);
        end
        @(posedge clock); #1;
        n_checks++;
        if (data_resultRDY !== 1'b0 || data_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rdy_one_cycle: rdy=%b data_out=%h, required 0/ffffffff",
                     data_resultRDY, data_out);
        end

        run_op(32'h8000_0000, 5'd31, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== 32'h0000_0001 || lat !== 5) begin
            n_fail++;
            $display("FAIL srl_80000000_31: got %h lat %0d, required 00000001 lat 5", res, lat);
        end

        run_op(32'hF0F0_F0F0, 5'd4, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'hFF0F_0F0F || lat !== 5) begin
            n_fail++;
            $display("FAIL sra_f0f0f0f0_4: got %h lat %0d, required ff0f0f0f lat 5", res, lat);
        end

        run_op(32'h1234_5678, 5'd0, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'h1234_5678 || lat !== 5) begin
            n_fail++;
            $display("FAIL shamt_zero: got %h lat %0d, required 12345678 lat 5", res, lat);
        end

        run_op(32'h7FFF_0001, 5'd16, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'h0000_7FFF) begin
            n_fail++;
            $display("FAIL sra_positive_16: got %h, required 00007fff", res);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_sweep();
        logic [31:0] ops [2];
        logic [31:0] res, exp_v;
        int lat, bb;
        ops[0] = 32'hFFFF_FFFF;
        ops[1] = 32'h7FFF_FFFF;
        for (int m = 0; m < 2; m++) begin
            for (int o = 0; o < 2; o++) begin
                for (int a = 0; a < 32; a++) begin
                    run_op(ops[o], 5'(a), 1'(m), res, lat, bb);
                    exp_v = (m == 1) ? 32'($signed(ops[o]) >>> a) : (ops[o] >> a);
                    n_checks++;
                    if (res !== exp_v || lat !== 5 || bb !== 0) begin
                        n_fail++;
                        $display("FAIL sweep arith=%0d op=%h amt=%0d: got %h lat %0d busybad %0d, required %h lat 5",
                                 m, ops[o], a, res, lat, bb, exp_v);
                    end
                end
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_start_ignored();
        int lat, pulses, busy_hi;
        data_in       = 32'h0000_FF00;
        ctrl_shiftamt = 5'd8;
        ctrl_arith    = 1'b0;
        ctrl_start    = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < 20) begin
            if (lat == 1) begin
                data_in = 32'hDEAD_BEEF; ctrl_shiftamt = 5'd3; ctrl_arith = 1'b1; ctrl_start = 1'b1;
            end else if (lat == 3) begin
                data_in = 32'h8000_0001; ctrl_shiftamt = 5'd1; ctrl_arith = 1'b1; ctrl_start = 1'b1;
            end else begin
                ctrl_start = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        ctrl_start = 1'b0;
        n_checks++;
        if (data_out !== 32'h0000_00FF || lat !== 5) begin
            n_fail++;
            $display("FAIL start_ignored_result: got %h lat %0d, required 000000ff lat 5", data_out, lat);
        end
        pulses  = 0;
        busy_hi = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) pulses++;
            if (busy === 1'b1) busy_hi++;
        end
        n_checks++;
        if (pulses !== 0 || busy_hi !== 0 || data_out !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL start_not_queued: extra rdy %0d busy %0d data_out %h, required 0/0/000000ff",
                     pulses, busy_hi, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bb;
        run_op(32'hF000_0000, 5'd28, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== 32'h0000_000F || lat !== 5 || bb !== 0) begin
            n_fail++;
            $display("FAIL b2b_first: got %h lat %0d busybad %0d, required 0000000f lat 5", res, lat, bb);
        end
        run_op(32'h8000_0000, 5'd1, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'hC000_0000 || lat !== 5 || bb !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: got %h lat %0d busybad %0d, required c0000000 lat 5", res, lat, bb);
        end
        run_op(32'h0000_0100, 5'd8, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== 32'h0000_0001 || lat !== 5 || bb !== 0) begin
            n_fail++;
            $display("FAIL b2b_third: got %h lat %0d busybad %0d, required 00000001 lat 5", res, lat, bb);
        end
        @(posedge clock); #1;
        n_checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: rdy=%b busy=%b, required 0/0", data_resultRDY, busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] res;
        int lat, bb, pulses;
        data_in       = 32'h8000_0000;
        ctrl_shiftamt = 5'd31;
        ctrl_arith    = 1'b1;
        ctrl_start    = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: data_out=%h busy=%b rdy=%b, required 0/0/0",
                     data_out, busy, data_resultRDY);
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) pulses++;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1 || data_out !== 32'h0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_no_completion: %0d bad samples, required 0", pulses);
        end
        run_op(32'hA5A5_A5A5, 5'd1, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'hD2D2_D2D2 || lat !== 5 || bb !== 0) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat %0d busybad %0d, required d2d2d2d2 lat 5", res, lat, bb);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
